// File: rtl/icsp_prog_loader_pkg.sv
// Shared constants for the ICSP program loader: command codes, frame
// geometry and FSM state encodings.
package icsp_prog_loader_pkg;

  localparam int ICSP_CMD_BITS     = 6;
  localparam int ICSP_FRAME_BITS   = 16;
  localparam int ICSP_PAYLOAD_BITS = 14;

  localparam logic [ICSP_CMD_BITS-1:0] ICSP_CMD_LOAD_DATA  = 6'h02;
  localparam logic [ICSP_CMD_BITS-1:0] ICSP_CMD_READ_DATA  = 6'h04;
  localparam logic [ICSP_CMD_BITS-1:0] ICSP_CMD_INC_ADDR   = 6'h06;
  localparam logic [ICSP_CMD_BITS-1:0] ICSP_CMD_BEGIN_PROG = 6'h08;
  localparam logic [ICSP_CMD_BITS-1:0] ICSP_CMD_LOAD_ADDR  = 6'h10;

  typedef enum logic [2:0] {
    ICSP_ST_IDLE     = 3'd0,
    ICSP_ST_CMD      = 3'd1,
    ICSP_ST_DATA_IN  = 3'd2,
    ICSP_ST_ADDR_IN  = 3'd3,
    ICSP_ST_RD_FETCH = 3'd4,
    ICSP_ST_DATA_OUT = 3'd5,
    ICSP_ST_WRITE    = 3'd6
  } icspState_t;

endpackage

// File: rtl/icsp_prog_loader_sync.sv
// Multi-stage synchronizer for an asynchronous pin, with single-clk
// rising and falling edge pulses taken from the synchronized level.
module icsp_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic asyncIn,
  output logic syncOut,
  output logic risePulse,
  output logic fallPulse
);

  logic [STAGES-1:0] chain;
  logic              prevLevel;

  // Shift the pin through the synchronizer and remember the last level.
  always_ff @(posedge clk) begin
    if (rst) begin
      chain     <= '0;
      prevLevel <= 1'b0;
    end else begin
      chain     <= {chain[STAGES-2:0], asyncIn};
      prevLevel <= chain[STAGES-1];
    end
  end

  assign syncOut   = chain[STAGES-1];
  assign risePulse = syncOut & ~prevLevel;
  assign fallPulse = ~syncOut & prevLevel;

endmodule

// File: rtl/icsp_prog_loader.sv
// ICSP programming port: receives serial commands and frames, writes and
// reads back program memory, and holds the CPU in reset while active.
//
// state    | meaning
// IDLE     | programming mode off, waiting for prog_en rising
// CMD      | shifting a 6-bit command; bitCnt==6 means decode this clk
// DATA_IN  | receiving a 16-cycle frame whose payload loads the data latch
// ADDR_IN  | receiving a 16-cycle frame whose payload loads mem_addr
// RD_FETCH | one clk to capture mem_rdata into the output shift register
// DATA_OUT | driving the 16-cycle readback frame on icsp_dout
// WRITE    | single clk with mem_we high
module icsp_prog_loader
  import icsp_prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH  = 11,
  parameter int DATA_WIDTH  = 12,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  prog_en,
  input  logic                  icsp_clk,
  input  logic                  icsp_din,
  output logic                  icsp_dout,
  output logic                  icsp_doe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  cpu_hold,
  output logic                  busy
);

  localparam logic [3:0] CMD_LAST   = 4'(ICSP_CMD_BITS);
  localparam logic [3:0] FRAME_LAST = 4'(ICSP_FRAME_BITS - 1);

  icspState_t state, stateNext;

  logic [3:0]                   bitCnt, bitCntNext;
  logic [ICSP_CMD_BITS-1:0]     cmdShift, cmdNext;
  logic [ICSP_PAYLOAD_BITS-1:0] shiftReg, shiftNext;
  logic [DATA_WIDTH-1:0]        dataLatch, latchNext;
  logic [ADDR_WIDTH-1:0]        addrNext;
  logic [DATA_WIDTH-1:0]        wdataNext;
  logic                         doeNext, doutNext;

  logic                   progSync, progRise, progFall;
  logic                   fallPulse, risePulse;
  logic                   unusedIcspClkLevel;
  logic [SYNC_STAGES-1:0] dinChain;
  logic                   icspDinSync;

  icsp_sync #(.STAGES(SYNC_STAGES)) progSyncInst (
    .clk       (clk),
    .rst       (rst),
    .asyncIn   (prog_en),
    .syncOut   (progSync),
    .risePulse (progRise),
    .fallPulse (progFall)
  );

  // Only the edges of the serial clock matter; its level is not used.
  icsp_sync #(.STAGES(SYNC_STAGES)) clkSyncInst (
    .clk       (clk),
    .rst       (rst),
    .asyncIn   (icsp_clk),
    .syncOut   (unusedIcspClkLevel),
    .risePulse (risePulse),
    .fallPulse (fallPulse)
  );

  // Data pin uses the same depth so it stays aligned with the clock edges.
  always_ff @(posedge clk) begin
    if (rst) dinChain <= '0;
    else     dinChain <= {dinChain[SYNC_STAGES-2:0], icsp_din};
  end

  assign icspDinSync = dinChain[SYNC_STAGES-1];

  // State, counters, shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ICSP_ST_IDLE;
      bitCnt    <= '0;
      cmdShift  <= '0;
      shiftReg  <= '0;
      dataLatch <= '1;
      mem_addr  <= '0;
      mem_wdata <= '1;
      icsp_doe  <= 1'b0;
      icsp_dout <= 1'b0;
    end else begin
      state     <= stateNext;
      bitCnt    <= bitCntNext;
      cmdShift  <= cmdNext;
      shiftReg  <= shiftNext;
      dataLatch <= latchNext;
      mem_addr  <= addrNext;
      mem_wdata <= wdataNext;
      icsp_doe  <= doeNext;
      icsp_dout <= doutNext;
    end
  end

  // Next-state and datapath decisions; prog_en edges override the FSM.
  always_comb begin
    stateNext  = state;
    bitCntNext = bitCnt;
    cmdNext    = cmdShift;
    shiftNext  = shiftReg;
    latchNext  = dataLatch;
    addrNext   = mem_addr;
    wdataNext  = mem_wdata;
    doeNext    = icsp_doe;
    doutNext   = icsp_dout;

    if (progFall) begin
      stateNext  = ICSP_ST_IDLE;
      bitCntNext = '0;
      cmdNext    = '0;
      doeNext    = 1'b0;
      doutNext   = 1'b0;
    end else if (progRise) begin
      stateNext  = ICSP_ST_CMD;
      bitCntNext = '0;
      cmdNext    = '0;
      addrNext   = '0;
      latchNext  = '1;
      doeNext    = 1'b0;
      doutNext   = 1'b0;
    end else begin
      case (state)
        ICSP_ST_IDLE: begin
        end

        ICSP_ST_CMD: begin
          if (bitCnt == CMD_LAST) begin
            bitCntNext = '0;
            case (cmdShift)
              ICSP_CMD_LOAD_DATA:  stateNext = ICSP_ST_DATA_IN;
              ICSP_CMD_READ_DATA:  stateNext = ICSP_ST_RD_FETCH;
              ICSP_CMD_INC_ADDR:   addrNext  = mem_addr + 1'b1;
              ICSP_CMD_BEGIN_PROG: begin
                stateNext = ICSP_ST_WRITE;
                wdataNext = dataLatch;
              end
              ICSP_CMD_LOAD_ADDR:  stateNext = ICSP_ST_ADDR_IN;
              default: begin
              end
            endcase
          end else if (fallPulse) begin
            cmdNext    = {icspDinSync, cmdShift[ICSP_CMD_BITS-1:1]};
            bitCntNext = bitCnt + 4'd1;
          end
        end

        ICSP_ST_DATA_IN, ICSP_ST_ADDR_IN: begin
          if (fallPulse) begin
            if (bitCnt == FRAME_LAST) begin
              bitCntNext = '0;
              stateNext  = ICSP_ST_CMD;
              if (state == ICSP_ST_DATA_IN) latchNext = shiftReg[DATA_WIDTH-1:0];
              else                          addrNext  = shiftReg[ADDR_WIDTH-1:0];
            end else begin
              // Start bit (count 0) carries no payload.
              if (bitCnt != 4'd0)
                shiftNext = {icspDinSync, shiftReg[ICSP_PAYLOAD_BITS-1:1]};
              bitCntNext = bitCnt + 4'd1;
            end
          end
        end

        ICSP_ST_RD_FETCH: begin
          shiftNext  = ICSP_PAYLOAD_BITS'(mem_rdata);
          stateNext  = ICSP_ST_DATA_OUT;
          bitCntNext = '0;
          // A frame-start rise landing on this clk must still open the driver.
          if (risePulse) begin
            doeNext  = 1'b1;
            doutNext = 1'b0;
          end
        end

        ICSP_ST_DATA_OUT: begin
          if (risePulse) begin
            if (bitCnt == 4'd0) begin
              doeNext  = 1'b1;
              doutNext = 1'b0;
            end else if (bitCnt == FRAME_LAST) begin
              doutNext = 1'b0;
            end else begin
              doutNext  = shiftReg[0];
              shiftNext = {1'b0, shiftReg[ICSP_PAYLOAD_BITS-1:1]};
            end
          end else if (fallPulse) begin
            if (bitCnt == FRAME_LAST) begin
              doeNext    = 1'b0;
              doutNext   = 1'b0;
              bitCntNext = '0;
              stateNext  = ICSP_ST_CMD;
            end else begin
              bitCntNext = bitCnt + 4'd1;
            end
          end
        end

        ICSP_ST_WRITE: begin
          stateNext  = ICSP_ST_CMD;
          bitCntNext = '0;
          // First bit of the next command may arrive in the write clk.
          if (fallPulse) begin
            cmdNext    = {icspDinSync, cmdShift[ICSP_CMD_BITS-1:1]};
            bitCntNext = 4'd1;
          end
        end

        default: stateNext = ICSP_ST_IDLE;
      endcase
    end
  end

  // Strobe is gated by rst so a write pending at reset is dropped.
  assign mem_we   = (state == ICSP_ST_WRITE) && !rst;
  // Keeping hold high during a write covers prog_en falling in that clk.
  assign cpu_hold = progSync | mem_we;
  assign busy     = !((state == ICSP_ST_IDLE) ||
                      ((state == ICSP_ST_CMD) && (bitCnt == 4'd0)));

endmodule

// File: tb/tb_icsp_prog_loader.sv
// Self-checking bench for icsp_prog_loader: drives the two-wire protocol,
// models program memory and scoreboards writes and readback frames.
module tb_icsp_prog_loader;

  localparam logic [5:0] C_LOAD_DATA  = 6'h02;
  localparam logic [5:0] C_READ_DATA  = 6'h04;
  localparam logic [5:0] C_INC_ADDR   = 6'h06;
  localparam logic [5:0] C_BEGIN_PROG = 6'h08;
  localparam logic [5:0] C_LOAD_ADDR  = 6'h10;

  logic        clk = 1'b0;
  logic        rst, prog_en, icsp_clk, icsp_din;
  logic        icsp_dout, icsp_doe, mem_we, cpu_hold, busy;
  logic [10:0] mem_addr;
  logic [11:0] mem_wdata, mem_rdata;

  icsp_prog_loader #(.ADDR_WIDTH(11), .DATA_WIDTH(12), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_en   (prog_en),
    .icsp_clk  (icsp_clk),
    .icsp_din  (icsp_din),
    .icsp_dout (icsp_dout),
    .icsp_doe  (icsp_doe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_rdata (mem_rdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Program memory behind the loader: registered read, one-clk write.
  logic [11:0] mem [0:2047];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [10:0] addr;
    logic [11:0] data;
  } wrRec_t;

  wrRec_t      wrQ[$];
  logic [13:0] rdQ[$];

  // Bench-side model of what the loader should hold.
  logic [11:0] modelMem [0:2047];
  logic [10:0] modelAddr;
  logic [11:0] modelLatch;

  // Every mem_we must match the oldest expected write.
  always @(negedge clk) begin
    if (mem_we) begin
      if (wrQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got mem_we=1 addr=%0h data=%0h, expected no write",
                 mem_addr, mem_wdata);
      end else begin
        wrRec_t e;
        e = wrQ.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_wdata), 32'(e.data));
        check("wr_cpu_hold", 32'(cpu_hold), 32'd1);
      end
    end
  end

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic sendBit(input logic b);
    icsp_din = b;
    icsp_clk = 1'b1;
    waitClk(5);
    icsp_clk = 1'b0;
    waitClk(5);
  endtask

  task automatic sendCmd(input logic [5:0] c);
    for (int i = 0; i < 6; i++) sendBit(c[i]);
  endtask

  task automatic sendFrame(input logic [13:0] p);
    sendBit(1'b0);
    for (int i = 0; i < 14; i++) sendBit(p[i]);
    sendBit(1'b1);
  endtask

  task automatic enter();
    prog_en = 1'b1;
    waitClk(6);
    modelAddr  = '0;
    modelLatch = 12'hFFF;
  endtask

  task automatic leave();
    prog_en = 1'b0;
    waitClk(6);
  endtask

  // Ignored payload bits are set to ones to show they are discarded.
  task automatic loadData(input logic [11:0] d);
    sendCmd(C_LOAD_DATA);
    sendFrame({2'b11, d});
    modelLatch = d;
  endtask

  task automatic loadAddr(input logic [10:0] a);
    sendCmd(C_LOAD_ADDR);
    sendFrame({3'b101, a});
    modelAddr = a;
  endtask

  task automatic incAddr();
    sendCmd(C_INC_ADDR);
    modelAddr = modelAddr + 11'd1;
  endtask

  task automatic beginProg();
    wrQ.push_back({modelAddr, modelLatch});
    modelMem[modelAddr] = modelLatch;
    sendCmd(C_BEGIN_PROG);
  endtask

  task automatic readData(input string name);
    logic [13:0] rx, exp;
    logic        doeAll, edgeBits;
    rdQ.push_back({2'b00, modelMem[modelAddr]});
    sendCmd(C_READ_DATA);
    check({name, "_doe_before"}, 32'(icsp_doe), 32'd0);
    rx       = '0;
    doeAll   = 1'b1;
    edgeBits = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      icsp_din = 1'b0;
      icsp_clk = 1'b1;
      waitClk(5);
      doeAll = doeAll & icsp_doe;
      if (c == 1 || c == 16) edgeBits = edgeBits | icsp_dout;
      else                   rx[c-2] = icsp_dout;
      icsp_clk = 1'b0;
      waitClk(5);
    end
    exp = rdQ.pop_front();
    check({name, "_payload"}, 32'(rx), 32'(exp));
    check({name, "_doe_frame"}, 32'(doeAll), 32'd1);
    check({name, "_start_stop"}, 32'(edgeBits), 32'd0);
    check({name, "_doe_after"}, 32'(icsp_doe), 32'd0);
  endtask

  typedef struct {
    logic [10:0] addr;
    logic [11:0] data;
    logic [10:0] expAddr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{addr: 11'h7FF, data: 12'h000, expAddr: 11'h7FF};
    vecs[1] = '{addr: 11'h400, data: 12'hFFF, expAddr: 11'h400};
    vecs[2] = '{addr: 11'h123, data: 12'h5A5, expAddr: 11'h123};
    vecs[3] = '{addr: 11'h001, data: 12'hABC, expAddr: 11'h001};

    for (int i = 0; i < 2048; i++) mem[i] = 12'h000;
    mem[3]      = 12'h3C1;
    modelMem[3] = 12'h3C1;

    rst = 1'b1; prog_en = 1'b0; icsp_clk = 1'b0; icsp_din = 1'b0;
    waitClk(4);
    rst = 1'b0;
    waitClk(1);
    check("rst_dout", 32'(icsp_dout), 32'd0);
    check("rst_doe", 32'(icsp_doe), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'hFFF);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    // Load and program one word at address 0.
    enter();
    check("t1_hold", 32'(cpu_hold), 32'd1);
    check("t1_busy_idle_cmd", 32'(busy), 32'd0);
    loadData(12'hA5C);
    check("t1_hold_mid", 32'(cpu_hold), 32'd1);
    beginProg();
    check("t1_write_done", 32'(wrQ.size()), 32'd0);

    // Increment to address 3 and read back the preloaded word.
    incAddr(); incAddr(); incAddr();
    check("t2_addr", 32'(mem_addr), 32'd3);
    readData("t2");

    // Address wrap from 2047 and write of the fresh latch value.
    leave();
    enter();
    loadAddr(11'h7FF);
    check("t3_addr_max", 32'(mem_addr), 32'h7FF);
    incAddr();
    check("t3_addr_wrap", 32'(mem_addr), 32'd0);
    beginProg();

    // Unknown command is ignored; then a normal load and two writes.
    sendCmd(6'h3F);
    check("t4_addr_kept", 32'(mem_addr), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    loadData(12'h123);
    beginProg();
    beginProg();
    check("t4_writes_done", 32'(wrQ.size()), 32'd0);

    // Abort mid-frame by dropping prog_en after 9 frame bits.
    loadAddr(11'h005);
    sendCmd(C_LOAD_DATA);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(i[0]);
    check("t5_busy_mid", 32'(busy), 32'd1);
    prog_en = 1'b0;
    waitClk(1);
    check("t5_hold_latency", 32'(cpu_hold), 32'd1);
    waitClk(3);
    check("t5_hold_low", 32'(cpu_hold), 32'd0);
    check("t5_busy_low", 32'(busy), 32'd0);
    check("t5_doe_low", 32'(icsp_doe), 32'd0);
    check("t5_addr_kept", 32'(mem_addr), 32'd5);
    enter();
    check("t5_reentry_addr", 32'(mem_addr), 32'd0);
    beginProg();

    // Table of address/data pairs: load, program, read back.
    for (int i = 0; i < 4; i++) begin
      loadAddr(vecs[i].addr);
      check("tbl_addr", 32'(mem_addr), 32'(vecs[i].expAddr));
      loadData(vecs[i].data);
      beginProg();
      readData("tbl_rd");
    end

    // rst arrives in the clk where the write would start.
    loadData(12'h777);
    for (int i = 0; i < 5; i++) sendBit(C_BEGIN_PROG[i]);
    icsp_din = C_BEGIN_PROG[5];
    icsp_clk = 1'b1;
    waitClk(5);
    icsp_clk = 1'b0;
    waitClk(3);
    rst = 1'b1;
    check("t6_we_at_rst", 32'(mem_we), 32'd0);
    waitClk(1);
    check("t6_we_after", 32'(mem_we), 32'd0);
    waitClk(1);
    check("t6_dout", 32'(icsp_dout), 32'd0);
    check("t6_doe", 32'(icsp_doe), 32'd0);
    check("t6_addr", 32'(mem_addr), 32'd0);
    check("t6_wdata", 32'(mem_wdata), 32'hFFF);
    check("t6_hold", 32'(cpu_hold), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    prog_en = 1'b0;
    waitClk(10);

    check("pending_writes", 32'(wrQ.size()), 32'd0);
    check("pending_reads", 32'(rdQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
